key_debounce: RTL
=================

# key_debounce

Front-end key conditioning stage for the 4-key board: synchronises the raw active-low key pins, filters contact bounce with an independent per-key stability counter, and presents clean levels plus single-cycle press/release strobes. It sits directly between the key pins and the LED pattern controller, whose key inputs are driven from `key_out`.

## Interface
- `KEY_W`, 4: number of keys.
- `CNT_MAX`, 999_999: debounce threshold. 20 ms at 50 MHz. A level must be stable for `CNT_MAX`+1 synchronised cycles to be accepted.
- `LONG_MAX`, 49_999_999: long-press threshold. 1 s at 50 MHz. Used only with `KEY_LONG_PRESS_EN`.
- `sys_clk` input 1: system clock, 50 MHz.
- `sys_rst_n` input 1: reset, asynchronous, active-low.
- `key_in` input `KEY_W`: raw key pins, active-low (0 = pressed), asynchronous to `sys_clk`.
- `key_out` output `KEY_W`: debounced level, active-low, registered.
- `key_press` output `KEY_W`: one-cycle pulse on debounced 1→0 of the corresponding key.
- `key_release` output `KEY_W`: one-cycle pulse on debounced 0→1.
- `key_long` output `KEY_W`: one-cycle pulse when a key has been held for `LONG_MAX`+1 cycles. Constant 0 when the feature is compiled out.

## Operation
- Synchroniser: two flops per key, `sync1` and then `sync2`. Both reset to 1.
- Per-key counter `cnt[i]`, width `$clog2(CNT_MAX+1)`, reset 0. All keys are fully independent; simultaneous activity on any subset of keys is handled in parallel.
  - `sync2[i]` == `key_out[i]`: `cnt[i]` <= 0. Any bounce restarts the count.
  - Mismatch and `cnt[i]` < `CNT_MAX`: `cnt[i]` increments.
  - Mismatch and `cnt[i]` == `CNT_MAX`: `key_out[i]` <= `sync2[i]` and `cnt[i]` <= 0.
  - In the same edge, `key_press[i]` <= 1 if the new level is 0, otherwise `key_release[i]` <= 1.
- Pulses are registered and last exactly one cycle. `key_press` and `key_release` are never both high for the same key.
- Counter never exceeds `CNT_MAX`; no wrap-around.
- Reset values: `key_out` = all 1s (released); `key_press`, `key_release`, `key_long` = 0; all counters 0.
- Reset asserted mid-count discards the count. A key held through reset release is accepted as a fresh press after full latency.

## Timing
- Take the edge that first samples the new level into `sync1` as edge 0.
- `key_out` and the press/release pulse update on edge `CNT_MAX`+2, provided `key_in` stays constant throughout.
- Any reversion of `sync2` before that edge returns `cnt` to 0. `key_out` is unchanged and no pulse is produced.
- A press and a release of the same key are each separately subject to the full debounce latency.

## Configuration
- Macro `KEY_LONG_PRESS_EN`.
- Defined: per-key hold counter `hold[i]`, width `$clog2(LONG_MAX+1)`, reset 0.
  - Increments while `key_out[i]` == 0.
  - On reaching `LONG_MAX` it pulses `key_long[i]` for one cycle, then saturates with no further pulses.
  - Cleared when `key_out[i]` returns to 1.
  - The press pulse occurs on the edge where `key_out` falls; `key_long` follows `LONG_MAX`+1 edges later.
- Undefined: no hold counters are built; `key_long` is tied to 0.

## Test plan
Bench uses `CNT_MAX`=9 and `LONG_MAX`=49.
- Clean press: drive `key_in[0]` 1→0 and hold. Required: `key_out[0]` falls and `key_press[0]` pulses high for exactly 1 cycle on edge 11. `key_release` stays 0.
- Bounce rejection: toggle `key_in[1]` with 0-pulses of 5 cycles separated by 3-cycle 1s, then hold 1. Required: `key_out` = 4'b1111 throughout and no pulses.
- Bounce then settle: after the bursts above, hold `key_in[1]` at 0. Required: exactly one `key_press[1]` pulse, 11 edges after the last 1→0 sample.
- Simultaneous keys: `key_in` 4'b1111→4'b0000 in one cycle. Required: all four `key_press` bits pulse on the same edge. Releasing to 4'b1111 gives all four `key_release` bits together.
- Reset mid-count: assert `sys_rst_n`=0 with `cnt[2]`=6. Required: immediate `key_out`=4'b1111, pulses 0 and counters 0. After reset release with the key still held, the press arrives 11 edges later.
- Long press (with `KEY_LONG_PRESS_EN`): hold `key_in[3]`=0 for 100 cycles. Required: one `key_long[3]` pulse 50 edges after `key_press[3]`, with no repeats. Without the macro, `key_long` stays 4'b0000.

Source files
------------

// File: rtl/key_debounce.sv
// +--------------------------------------------------------------------------+
// | key_debounce: 2-flop sync + per-key stability filter, press/release/long |
// | strobes. Optional long-press hold counters via KEY_LONG_PRESS_EN. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module key_debounce #(
  parameter int unsigned KEY_W    = 4,
  parameter int unsigned CNT_MAX  = 999_999,
  parameter int unsigned LONG_MAX = 49_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  localparam int unsigned            c_CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [c_CNT_W-1:0]     c_CNT_MAX = c_CNT_W'(CNT_MAX);

  // Zero thresholds would collapse the counters to zero width.
  if (CNT_MAX == 0 || LONG_MAX == 0) begin : g_param_check
    $error("key_debounce: CNT_MAX and LONG_MAX must be nonzero");
  end

  logic [KEY_W-1:0]   sync1_q;
  logic [KEY_W-1:0]   sync2_q;
  logic [KEY_W-1:0]   key_out_q,   key_out_d;
  logic [KEY_W-1:0]   press_q,     press_d;
  logic [KEY_W-1:0]   release_q,   release_d;
  logic [c_CNT_W-1:0] cnt_q [KEY_W];
  logic [c_CNT_W-1:0] cnt_d [KEY_W];

  always_comb begin
    key_out_d = key_out_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != key_out_q[i]) begin
        if (cnt_q[i] == c_CNT_MAX) begin
          key_out_d[i] = sync2_q[i];
          press_d[i]   = ~sync2_q[i];
          release_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      key_out_q <= '1;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < int'(KEY_W); i++) cnt_q[i] <= '0;
    end else begin
      sync1_q   <= key_in;
      sync2_q   <= sync1_q;
      key_out_q <= key_out_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < int'(KEY_W); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign key_out     = key_out_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned         c_LONG_W   = $clog2(LONG_MAX + 1);
  localparam logic [c_LONG_W-1:0] c_LONG_MAX = c_LONG_W'(LONG_MAX);

  logic [c_LONG_W-1:0] hold_q [KEY_W];
  logic [c_LONG_W-1:0] hold_d [KEY_W];
  logic [KEY_W-1:0]    done_q, done_d;
  logic [KEY_W-1:0]    long_q, long_d;

  // done_q keeps the saturated counter from re-firing the strobe.
  always_comb begin
    done_d = done_q;
    long_d = '0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      hold_d[i] = hold_q[i];
      if (key_out_q[i]) begin
        hold_d[i] = '0;
        done_d[i] = 1'b0;
      end else if (hold_q[i] != c_LONG_MAX) begin
        hold_d[i] = hold_q[i] + 1'b1;
      end else if (!done_q[i]) begin
        long_d[i] = 1'b1;
        done_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      done_q <= '0;
      long_q <= '0;
      for (int i = 0; i < int'(KEY_W); i++) hold_q[i] <= '0;
    end else begin
      done_q <= done_d;
      long_q <= long_d;
      for (int i = 0; i < int'(KEY_W); i++) hold_q[i] <= hold_d[i];
    end
  end

  assign key_long = long_q;
`else
  assign key_long = '0;
`endif

endmodule

`default_nettype wire
